elm_mitchell_pipe: RTL and testbench

- Parametrised, pipelined successor to the 16-bit combinational hybrid Booth/Mitchell approximate signed multiplier.
- Operand width and the exact/approximate split point are generic, and approximate or exact mode is selected per transaction.
- Operands pass through a 3-stage pipeline with valid/ready handshake, backpressure and a tag sideband.
- Sits between operand FIFOs and accumulator/datapath consumers in the approximate-arithmetic datapath.

---
 rtl/elm_pkg.sv | 42 ++++
 rtl/elm_mitchell_pipe_log.sv | 32 +++
 rtl/elm_mitchell_pipe.sv | 182 ++++++++++++++++++
 tb/tb_elm_mitchell_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/elm_pkg.sv
// Shared encodings, log-word layout and Booth digit helpers for the
// pipelined hybrid Booth/Mitchell multiplier.
package elm_pkg;

   localparam logic MODE_APPROX = 1'b0;
   localparam logic MODE_EXACT  = 1'b1;

   localparam int LOG_KW = 6;
   localparam int LOG_FW = 32;

   localparam int BOOTH_ONE = 0;
   localparam int BOOTH_TWO = 1;
   localparam int BOOTH_NEG = 2;

   typedef struct packed {
      logic [LOG_KW-1:0] k;
      logic [LOG_FW-1:0] f;
   } log_word_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((32'sd1 <<< r) < value) begin
         r = r + 32'sd1;
      end
      return r;
   endfunction

   // Radix-4 digit from an overlapping multiplier triplet {b[2i+1], b[2i], b[2i-1]}
   function automatic logic [2:0] booth_enc(input logic [2:0] trip);
      logic [2:0] ctl;
      case (trip)
         3'b001, 3'b010: ctl = 3'b001;
         3'b011:         ctl = 3'b010;
         3'b100:         ctl = 3'b110;
         3'b101, 3'b110: ctl = 3'b101;
         default:        ctl = 3'b000;
      endcase
      return ctl;
   endfunction

endpackage

// File: rtl/elm_mitchell_pipe_log.sv
// Mitchell log front end: one's-complement magnitude, leading-one position
// and the FRAC mantissa bits that follow it.
module mitchell_log_core
   import elm_pkg::*;
#(
   parameter int SPLIT = 14,
   parameter int FRAC  = 5
) (
   input  logic [SPLIT-1:0] a,
   output log_word_t        lw
);

   localparam int KW = clog2(SPLIT);

   logic [SPLIT-1:0] mag_s;
   logic [SPLIT-1:0] norm_s;
   logic [KW-1:0]    k_s;

   // Normalising the leading one to the top bit leaves f directly below it; a zero magnitude yields k=0, f=0
   always_comb begin
      mag_s = a ^ {SPLIT{a[SPLIT-1]}};
      k_s   = '0;
      for (int i = 0; i < SPLIT; i++) begin
         k_s = mag_s[i] ? KW'(i) : k_s;
      end
      norm_s = mag_s << (KW'(SPLIT - 1) - k_s);
      lw     = '0;
      lw.k   = LOG_KW'(k_s);
      lw.f   = LOG_FW'(FRAC'(norm_s >> (SPLIT - 1 - FRAC)));
   end

endmodule

// File: rtl/elm_mitchell_pipe.sv
// Three-stage valid/ready hybrid Booth/Mitchell signed multiplier with a
// per-transaction exact/approximate mode and a tag sideband.
module elm_mitchell_pipe
   import elm_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SPLIT = 14,
   parameter int FRAC  = 5,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_mode,
   input  logic [WIDTH-1:0]   in_x,
   input  logic [WIDTH-1:0]   in_y,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_p,
   output logic [TAG_W-1:0]   out_tag
);

   localparam int HW  = WIDTH - SPLIT + 1;
   localparam int PW  = 2 * WIDTH;
   localparam int OW  = WIDTH + 2;
   localparam int ND  = OW / 2 + 1;
   localparam int BW  = 2 * OW;
   localparam int AW  = 2 * SPLIT + FRAC;
   localparam int MW  = 2 * SPLIT;

   // Radix-4 Booth product; negated digits add their +1 as a separate sign-factor term
   function automatic logic [BW-1:0] booth_mul(input logic [OW-1:0] a, input logic [OW-1:0] b);
      logic [2*ND:0]   bx;
      logic [BW-1:0]   ax;
      logic [BW-1:0]   pp;
      logic [BW-1:0]   acc;
      logic [2:0]      ctl;
      bx  = {{(2*ND-OW){b[OW-1]}}, b, 1'b0};
      ax  = {{(BW-OW){a[OW-1]}}, a};
      acc = '0;
      for (int i = 0; i < ND; i++) begin
         ctl = booth_enc(bx[2*i +: 3]);
         pp  = ctl[BOOTH_TWO] ? (ax << 1) : (ctl[BOOTH_ONE] ? ax : '0);
         pp  = ctl[BOOTH_NEG] ? ~pp : pp;
         acc = acc + (pp << (2*i)) + (BW'(ctl[BOOTH_NEG]) << (2*i));
      end
      return acc;
   endfunction

   logic s3_free_s, s2_free_s;
   logic signed [HW-1:0] xh_s, yh_s;
   log_word_t lwx_s, lwy_s;

   logic                     s1_valid_r, s1_mode_r;
   logic [TAG_W-1:0]         s1_tag_r;
   logic signed [HW-1:0]     s1_xh_r, s1_yh_r;
   logic signed [SPLIT-1:0]  s1_xl_r, s1_yl_r;
   logic signed [WIDTH-1:0]  s1_y_r;
   log_word_t                s1_lwx_r, s1_lwy_r;

   logic [LOG_FW-1:0] fsum_s;
   log_word_t         lsum_s;
   logic [AW-1:0]     ant_s;
   logic [MW-1:0]     mant_s, m_s;
   logic [PW-1:0]     row_a_s, row_b_s, row_c_s, sum_s;

   logic              s2_valid_r;
   logic [TAG_W-1:0]  s2_tag_r;
   logic [PW-1:0]     s2_row_a_r, s2_row_b_r, s2_row_c_r;

   // Stage k may load whenever stage k+1 is empty or draining this cycle
   always_comb begin
      s3_free_s = ~out_valid | out_ready;
      s2_free_s = ~s2_valid_r | s3_free_s;
      in_ready  = ~s1_valid_r | s2_free_s;
   end

   // High halves carry the x[SPLIT-1] overlap bit so that x = xh*2^SPLIT + signed(xl)
   always_comb begin
      xh_s = HW'($signed(in_x[WIDTH-1:SPLIT])) + HW'(in_x[SPLIT-1]);
      yh_s = HW'($signed(in_y[WIDTH-1:SPLIT])) + HW'(in_y[SPLIT-1]);
   end

   mitchell_log_core #(.SPLIT(SPLIT), .FRAC(FRAC)) u_log_x (
      .a  (in_x[SPLIT-1:0]),
      .lw (lwx_s)
   );

   mitchell_log_core #(.SPLIT(SPLIT), .FRAC(FRAC)) u_log_y (
      .a  (in_y[SPLIT-1:0]),
      .lw (lwy_s)
   );

   // S1: capture decomposed operands and log words
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_mode_r  <= MODE_APPROX;
         s1_tag_r   <= '0;
         s1_xh_r    <= '0;
         s1_yh_r    <= '0;
         s1_xl_r    <= '0;
         s1_yl_r    <= '0;
         s1_y_r     <= '0;
         s1_lwx_r   <= '0;
         s1_lwy_r   <= '0;
      end else if (in_ready) begin
         s1_valid_r <= in_valid;
         if (in_valid) begin
            s1_mode_r <= in_mode;
            s1_tag_r  <= in_tag;
            s1_xh_r   <= xh_s;
            s1_yh_r   <= yh_s;
            s1_xl_r   <= in_x[SPLIT-1:0];
            s1_yl_r   <= in_y[SPLIT-1:0];
            s1_y_r    <= in_y;
            s1_lwx_r  <= lwx_s;
            s1_lwy_r  <= lwy_s;
         end
      end
   end

   // Log add with fraction carry into k, truncating antilog, then the three partial rows
   always_comb begin
      fsum_s   = s1_lwx_r.f + s1_lwy_r.f;
      lsum_s.k = s1_lwx_r.k + s1_lwy_r.k + LOG_KW'(fsum_s[FRAC]);
      lsum_s.f = fsum_s & ((LOG_FW'(1) << FRAC) - LOG_FW'(1));
      ant_s    = ((AW'(1) << FRAC) | AW'(lsum_s.f)) << lsum_s.k;
      mant_s   = MW'(ant_s >> FRAC);
      m_s      = ((s1_xl_r == '0) || (s1_yl_r == '0)) ? '0 :
                 ((s1_xl_r[SPLIT-1] ^ s1_yl_r[SPLIT-1]) ? ~mant_s : mant_s);
      row_a_s  = PW'(booth_mul(OW'(s1_xh_r), OW'(s1_y_r)) << SPLIT);
      row_b_s  = PW'(booth_mul(OW'(s1_xl_r), OW'(s1_yh_r)) << SPLIT);
      if (s1_mode_r == MODE_EXACT) begin
         row_c_s = PW'(booth_mul(OW'(s1_xl_r), OW'(s1_yl_r)));
      end else begin
         row_c_s = {{(PW-MW){m_s[MW-1]}}, m_s};
      end
   end

   // S2: register partial rows
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_r <= 1'b0;
         s2_tag_r   <= '0;
         s2_row_a_r <= '0;
         s2_row_b_r <= '0;
         s2_row_c_r <= '0;
      end else if (s2_free_s) begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            s2_tag_r   <= s1_tag_r;
            s2_row_a_r <= row_a_s;
            s2_row_b_r <= row_b_s;
            s2_row_c_r <= row_c_s;
         end
      end
   end

   // Final carry-propagate sum of the three rows
   always_comb begin
      sum_s = s2_row_a_r + s2_row_b_r + s2_row_c_r;
   end

   // S3: output register, held while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_p     <= '0;
         out_tag   <= '0;
      end else if (s3_free_s) begin
         out_valid <= s2_valid_r;
         if (s2_valid_r) begin
            out_p   <= sum_s;
            out_tag <= s2_tag_r;
         end
      end
   end

endmodule

// File: tb/tb_elm_mitchell_pipe.sv
// Scoreboard bench for elm_mitchell_pipe: directed vectors with hand-computed
// products, stall/backpressure streaming and mid-flight reset.
module tb_elm_mitchell_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_mode;
   logic [15:0] in_x, in_y;
   logic [3:0]  in_tag, out_tag;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_p;

   typedef struct {
      logic [31:0] p;
      logic [3:0]  tag;
   } exp_t;

   typedef struct {
      logic        mode;
      logic [15:0] x;
      logic [15:0] y;
      logic [31:0] p;
   } vec_t;

   // mode 0 = approximate, 1 = exact
   vec_t dir [14] = '{
      '{1'b0, 16'h0003, 16'h0003, 32'h0000_0008},
      '{1'b1, 16'h0003, 16'h0003, 32'h0000_0009},
      '{1'b0, 16'hFFFC, 16'h0004, 32'hFFFF_FFF3},
      '{1'b1, 16'hFFFC, 16'h0004, 32'hFFFF_FFF0},
      '{1'b0, 16'h4001, 16'h0002, 32'h0000_8002},
      '{1'b0, 16'hFFFF, 16'hFFFF, 32'h0000_0001},
      '{1'b0, 16'h0000, 16'h8000, 32'h0000_0000},
      '{1'b1, 16'h8000, 16'h8000, 32'h4000_0000},
      '{1'b0, 16'h0005, 16'h0007, 32'h0000_0020},
      '{1'b0, 16'h0064, 16'h0064, 32'h0000_2400},
      '{1'b0, 16'h0006, 16'hFFFB, 32'hFFFF_FFE7},
      '{1'b0, 16'h2000, 16'h0003, 32'h0000_61FF},
      '{1'b1, 16'h04D2, 16'hFDC9, 32'hFFF5_52E2},
      '{1'b1, 16'h7FFF, 16'h8000, 32'hC000_8000}
   };

   exp_t        sb[$];
   exp_t        e;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          ready_mode = 0;
   logic [3:0]  pat = 4'b1001;
   logic        hold_pend = 1'b0;
   logic [31:0] held_p;
   logic [3:0]  held_tag;
   int          acc;

   elm_mitchell_pipe #(.WIDTH(16), .SPLIT(14), .FRAC(5), .TAG_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_x      (in_x),
      .in_y      (in_y),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // consumer: always ready, 1,0,0,1 pattern, or fully stalled
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = pat[cyc[1:0]];
         default: out_ready = 1'b0;
      endcase
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", name, got, want);
      end
   endtask

   // monitor: compares every delivered result and the held value during stalls
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend)
            check("stall_hold", {27'd0, out_valid, out_tag, out_p}, {27'd0, 1'b1, held_tag, held_p});
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_out: got p=0x%0h tag=%0d with nothing outstanding", out_p, out_tag);
            end else begin
               e = sb.pop_front();
               check("result_p", 64'(out_p), 64'(e.p));
               check("result_tag", 64'(out_tag), 64'(e.tag));
            end
            hold_pend = 1'b0;
         end else if (out_valid) begin
            hold_pend = 1'b1;
            held_p    = out_p;
            held_tag  = out_tag;
         end else begin
            hold_pend = 1'b0;
         end
      end
   end

   task automatic send(input vec_t v, input logic [3:0] tag, output int a);
      exp_t item;
      in_valid = 1'b1;
      in_mode  = v.mode;
      in_x     = v.x;
      in_y     = v.y;
      in_tag   = tag;
      a        = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            item.p   = v.p;
            item.tag = tag;
            sb.push_back(item);
            a = cyc + 1;
            break;
         end
      end
      if (a < 0) begin
         total++;
         bad++;
         $display("FAIL send_timeout: in_ready stayed 0 for tag %0d", tag);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input int a, input string name);
      int seen;
      seen = -100;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = cyc;
            break;
         end
      end
      check(name, 64'(seen - a), 64'(2));
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 200; i++) begin
         if (sb.size() == 0) break;
         @(posedge clk);
      end
      check(name, 64'(sb.size()), 64'(0));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_mode  = 1'b0;
      in_x     = 16'h0000;
      in_y     = 16'h0000;
      in_tag   = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_p", 64'(out_p), 64'(0));
      check("rst_out_tag", 64'(out_tag), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;

      // isolated transactions: value and 3-stage latency
      for (int i = 0; i < 14; i++) begin
         send(dir[i], 4'(i + 1), acc);
         wait_out(acc, "latency");
      end

      // mixed-mode stream, tags 0..7, consumer toggling 1,0,0,1
      ready_mode = 1;
      for (int i = 0; i < 8; i++) send(dir[i], 4'(i), acc);
      drain("stream_drain");
      ready_mode = 0;

      // fill all three stages against a stalled consumer
      ready_mode = 2;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) send(dir[8 + i], 4'(i + 1), acc);
      @(negedge clk);
      check("full_in_ready", 64'(in_ready), 64'(0));
      check("full_out_valid", 64'(out_valid), 64'(1));
      repeat (3) @(posedge clk);
      #1;
      ready_mode = 0;
      drain("full_drain");

      // reset with three transactions in flight
      ready_mode = 2;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) send(dir[11 + i], 4'(i + 9), acc);
      rst_n = 1'b0;
      #1;
      check("rst_flush_valid", 64'(out_valid), 64'(0));
      check("rst_flush_ready", 64'(in_ready), 64'(1));
      sb.delete();
      @(posedge clk);
      #1;
      rst_n      = 1'b1;
      ready_mode = 0;
      repeat (6) @(posedge clk);
      #1;
      check("post_rst_idle", 64'(out_valid), 64'(0));
      send(dir[12], 4'hC, acc);
      wait_out(acc, "rst_latency");
      drain("final_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
